// File: rtl/commit_fence_sequencer_pkg.sv
// Shared types for the commit fence sequencer: FSM states and the
// accepted-request kind captured when a fence-type instruction retires.
package commit_fence_sequencer_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_DFLUSH = 3'd2,
        ST_IFLUSH = 3'd3,
        ST_TLB    = 3'd4,
        ST_DONE   = 3'd5
    } fence_state_e;

    typedef struct packed {
        logic sfence;
        logic fence_i;
        logic fence;
    } fence_kind_t;

    // FENCE and FENCE.I both need dirty D$ lines written back first.
    function automatic logic needs_dflush(fence_kind_t kind);
        return kind.fence | kind.fence_i;
    endfunction

endpackage

// File: rtl/commit_fence_sequencer_if.sv
// Commit-side requests and cache/MMU flush handshakes of the fence sequencer.
interface commit_fence_sequencer_if;

    logic fence_req_i;
    logic fence_i_req_i;
    logic sfence_vma_req_i;
    logic halt_i;
    logic no_st_pending_i;
    logic dcache_flush_o;
    logic dcache_flush_ack_i;
    logic icache_flush_o;
    logic tlb_flush_o;
    logic flush_pipeline_o;
    logic done_o;
    logic busy_o;
    logic error_o;

    modport master (
        output fence_req_i, fence_i_req_i, sfence_vma_req_i, halt_i,
        output no_st_pending_i, dcache_flush_ack_i,
        input  dcache_flush_o, icache_flush_o, tlb_flush_o,
        input  flush_pipeline_o, done_o, busy_o, error_o
    );

    modport slave (
        input  fence_req_i, fence_i_req_i, sfence_vma_req_i, halt_i,
        input  no_st_pending_i, dcache_flush_ack_i,
        output dcache_flush_o, icache_flush_o, tlb_flush_o,
        output flush_pipeline_o, done_o, busy_o, error_o
    );

endinterface

// File: rtl/commit_fence_sequencer_timeout_cnt.sv
// Saturating wait counter; tc_c_o flags the last allowed wait cycle.
module fence_timeout_cnt
    import commit_fence_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables the timeout entirely.
    assign tc_c_o = (TIMEOUT_CYCLES != 0) && en_i
                 && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/commit_fence_sequencer.sv
// Sequences store drain, D$/I$/TLB flushes and the pipeline flush after a
// retired FENCE, FENCE.I or SFENCE.VMA; overlapping requests are merged.
module commit_fence_sequencer
    import commit_fence_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    commit_fence_sequencer_if.slave bus
);

    fence_state_e state_q, state_d;
    fence_kind_t  kind_q, kind_d;
    fence_kind_t  req_kind;
    logic         error_q, error_d;
    logic         tc;
    logic         wait_en;

    logic dcache_flush_q, icache_flush_q, tlb_flush_q, done_q, busy_q;

    assign req_kind.sfence  = bus.sfence_vma_req_i;
    assign req_kind.fence_i = bus.fence_i_req_i;
    assign req_kind.fence   = bus.fence_req_i;

    assign wait_en = (state_q == ST_DRAIN) || (state_q == ST_DFLUSH);

    fence_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (state_d != state_q),
        .en_i    (wait_en),
        .tc_c_o  (tc)
    );

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        error_d = error_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((|req_kind) && !bus.halt_i) begin
                    state_d = ST_DRAIN;
                    kind_d  = req_kind;
                    error_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (bus.no_st_pending_i || tc) begin
                    error_d = error_q | !bus.no_st_pending_i;
                    state_d = needs_dflush(kind_q) ? ST_DFLUSH : ST_TLB;
                end
            end
            ST_DFLUSH: begin
                if (bus.dcache_flush_ack_i || tc) begin
                    error_d = error_q | !bus.dcache_flush_ack_i;
                    if (kind_q.fence_i)     state_d = ST_IFLUSH;
                    else if (kind_q.sfence) state_d = ST_TLB;
                    else                    state_d = ST_DONE;
                end
            end
            ST_IFLUSH: state_d = kind_q.sfence ? ST_TLB : ST_DONE;
            ST_TLB:    state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            kind_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            error_q <= error_d;
        end
    end

    // Outputs are flopped decodes of the next state, so they track state_q exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dcache_flush_q <= 1'b0;
            icache_flush_q <= 1'b0;
            tlb_flush_q    <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            dcache_flush_q <= (state_d == ST_DFLUSH);
            icache_flush_q <= (state_d == ST_IFLUSH);
            tlb_flush_q    <= (state_d == ST_TLB);
            done_q         <= (state_d == ST_DONE);
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    assign bus.dcache_flush_o   = dcache_flush_q;
    assign bus.icache_flush_o   = icache_flush_q;
    assign bus.tlb_flush_o      = tlb_flush_q;
    assign bus.done_o           = done_q;
    assign bus.flush_pipeline_o = done_q;
    assign bus.busy_o           = busy_q;
    assign bus.error_o          = error_q;

endmodule

// File: tb/tb_commit_fence_sequencer.sv
// Scoreboard bench for commit_fence_sequencer: stimulus queues expected flush
// events with their cycle; a negedge monitor pops and compares each event.
module tb_commit_fence_sequencer;

    localparam int unsigned TO = 8;

    typedef enum int {EV_DFL = 0, EV_IFL = 1, EV_TLB = 2, EV_DONE = 3} ev_e;
    typedef struct {
        ev_e  ev;
        int   at;
        logic err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic dfl_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    commit_fence_sequencer_if bus();

    commit_fence_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input ev_e e, input int at, input logic err = 1'b0);
        exp_q.push_back('{e, at, err});
    endtask

    task automatic handle(input ev_e e);
        exp_t x;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got event %0d at cycle %0d expected none", int'(e), cyc);
        end else begin
            x = exp_q.pop_front();
            chk("event_kind", int'(e), int'(x.ev));
            chk("event_cycle", cyc, x.at);
            if (e == EV_DONE) begin
                chk("done_o", int'(bus.done_o), 1);
                chk("flush_pipeline_o", int'(bus.flush_pipeline_o), 1);
                chk("error_at_done", int'(bus.error_o), int'(x.err));
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.dcache_flush_o && !dfl_prev) handle(EV_DFL);
        if (bus.icache_flush_o)              handle(EV_IFL);
        if (bus.tlb_flush_o)                 handle(EV_TLB);
        if (bus.done_o || bus.flush_pipeline_o) handle(EV_DONE);
        dfl_prev = bus.dcache_flush_o;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dcache_flush"}, int'(bus.dcache_flush_o), 0);
        chk({tag, "_icache_flush"}, int'(bus.icache_flush_o), 0);
        chk({tag, "_tlb_flush"},    int'(bus.tlb_flush_o), 0);
        chk({tag, "_flush_pipe"},   int'(bus.flush_pipeline_o), 0);
        chk({tag, "_done"},         int'(bus.done_o), 0);
        chk({tag, "_busy"},         int'(bus.busy_o), 0);
        chk({tag, "_error"},        int'(bus.error_o), 0);
    endtask

    initial begin
        int r;
        bus.fence_req_i        = 1'b0;
        bus.fence_i_req_i      = 1'b0;
        bus.sfence_vma_req_i   = 1'b0;
        bus.halt_i             = 1'b0;
        bus.no_st_pending_i    = 1'b1;
        bus.dcache_flush_ack_i = 1'b0;

        step(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        step(2);

        // FENCE, ack one cycle after flush is visible -> done at +4
        r = cyc;
        bus.fence_req_i = 1'b1;
        expect_ev(EV_DFL, r + 2);
        expect_ev(EV_DONE, r + 4);
        step();
        bus.fence_req_i = 1'b0;
        chk("fence_busy", int'(bus.busy_o), 1);
        step(2);
        bus.dcache_flush_ack_i = 1'b1;
        step();
        bus.dcache_flush_ack_i = 1'b0;
        step(4);

        // FENCE.I with store buffer busy for 5 cycles
        bus.no_st_pending_i = 1'b0;
        r = cyc;
        bus.fence_i_req_i = 1'b1;
        expect_ev(EV_DFL, r + 6);
        expect_ev(EV_IFL, r + 7);
        expect_ev(EV_DONE, r + 8);
        step();
        bus.fence_i_req_i = 1'b0;
        step(3);
        chk("drain_no_dflush", int'(bus.dcache_flush_o), 0);
        step();
        bus.no_st_pending_i = 1'b1;
        step();
        bus.dcache_flush_ack_i = 1'b1;
        step();
        bus.dcache_flush_ack_i = 1'b0;
        step(3);

        // Merged FENCE + FENCE.I + SFENCE.VMA
        r = cyc;
        bus.fence_req_i = 1'b1;
        bus.fence_i_req_i = 1'b1;
        bus.sfence_vma_req_i = 1'b1;
        expect_ev(EV_DFL, r + 2);
        expect_ev(EV_IFL, r + 3);
        expect_ev(EV_TLB, r + 4);
        expect_ev(EV_DONE, r + 5);
        step();
        bus.fence_req_i = 1'b0;
        bus.fence_i_req_i = 1'b0;
        bus.sfence_vma_req_i = 1'b0;
        step();
        bus.dcache_flush_ack_i = 1'b1;
        step();
        bus.dcache_flush_ack_i = 1'b0;
        step(4);

        // Request while halted is dropped
        bus.halt_i = 1'b1;
        bus.fence_req_i = 1'b1;
        step();
        bus.fence_req_i = 1'b0;
        chk("halt_busy_1", int'(bus.busy_o), 0);
        step();
        chk("halt_busy_2", int'(bus.busy_o), 0);
        bus.halt_i = 1'b0;
        step(2);

        // SFENCE only; requests while busy and in DONE are dropped, halt doesn't abort
        r = cyc;
        bus.sfence_vma_req_i = 1'b1;
        expect_ev(EV_TLB, r + 2);
        expect_ev(EV_DONE, r + 3);
        step();
        bus.sfence_vma_req_i = 1'b0;
        bus.fence_req_i = 1'b1;
        bus.halt_i = 1'b1;
        step();
        bus.fence_req_i = 1'b0;
        bus.halt_i = 1'b0;
        step();
        bus.fence_req_i = 1'b1;
        step();
        bus.fence_req_i = 1'b0;
        chk("drop_in_done_busy", int'(bus.busy_o), 0);
        step(6);

        // D$ ack never arrives: timeout after 8 DFLUSH cycles
        r = cyc;
        bus.fence_req_i = 1'b1;
        expect_ev(EV_DFL, r + 2);
        expect_ev(EV_DONE, r + 10, 1'b1);
        step();
        bus.fence_req_i = 1'b0;
        step(8);
        chk("timeout_dflush_held", int'(bus.dcache_flush_o), 1);
        step();
        chk("timeout_error", int'(bus.error_o), 1);
        chk("timeout_dflush_drop", int'(bus.dcache_flush_o), 0);
        step(2);
        chk("error_sticky", int'(bus.error_o), 1);
        r = cyc;
        bus.sfence_vma_req_i = 1'b1;
        expect_ev(EV_TLB, r + 2);
        expect_ev(EV_DONE, r + 3);
        step();
        bus.sfence_vma_req_i = 1'b0;
        chk("error_cleared", int'(bus.error_o), 0);
        step(5);

        // Reset while in DFLUSH aborts with no done
        r = cyc;
        bus.fence_req_i = 1'b1;
        expect_ev(EV_DFL, r + 2);
        step();
        bus.fence_req_i = 1'b0;
        step(2);
        chk("pre_reset_dflush", int'(bus.dcache_flush_o), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        step(2);
        rst_n = 1'b1;
        step(15);

        chk("pending_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
